lfsr_range_rng: RTL and testbench

Parametrised, clocked pseudo-random number source for the game logic. A WIDTH-bit Fibonacci LFSR feeds a bit-serial restoring divider, which reduces each draw to the run-time range 1..range_max. The block supports run-time seeding, all-zero lockup recovery, an optional free-running mode, and request/result handshakes. It sits between the game controller (requester) and the word/target selection logic (result consumer).

---
 rtl/lfsr_range_rng_if.sv | 25 ++
 rtl/lfsr_range_rng.sv | 114 +++++++++++
 tb/tb_lfsr_range_rng.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_range_rng_if.sv
// Request/result bundle between the game controller (master) and the range RNG (slave).
interface lfsr_range_rng_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned OUT_W = 7
) ();
  logic             seed_load;
  logic [WIDTH-1:0] seed;
  logic             req;
  logic             req_ready;
  logic [OUT_W-1:0] range_max;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] value;
  logic             busy;

  modport master (
    output seed_load, seed, req, range_max, out_ready,
    input  req_ready, out_valid, value, busy
  );

  modport slave (
    input  seed_load, seed, req, range_max, out_ready,
    output req_ready, out_valid, value, busy
  );
endinterface

// File: rtl/lfsr_range_rng.sv
// Fibonacci LFSR draw reduced to 1..range_max by a bit-serial restoring divider.
// range_max of 0 bypasses the reduction and returns the low bits of the draw.
module lfsr_range_rng #(
  parameter int unsigned      WIDTH      = 16,
  parameter int unsigned      OUT_W      = 7,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] RESET_SEED = WIDTH'(1),
  parameter bit               FREE_RUN   = 1'b0
) (
  input logic             clk,
  input logic             reset,
  lfsr_range_rng_if.slave bus
);
  localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] SEED_INIT = (RESET_SEED == '0) ? WIDTH'(1) : RESET_SEED;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StDiv  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [OUT_W-1:0] byp_q, byp_d;
  logic [OUT_W-1:0] m_q, m_d;
  logic [OUT_W:0]   rem_q, rem_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] value_q, value_d;

  logic [WIDTH-1:0] lfsr_step;
  logic [OUT_W+1:0] t, t_red, m_ext;

  // All-zero is the lockup state, so any load or step landing there becomes 1.
  function automatic logic [WIDTH-1:0] no_zero(input logic [WIDTH-1:0] x);
    return (x == '0) ? WIDTH'(1) : x;
  endfunction

  assign lfsr_step = no_zero({lfsr_q[WIDTH-2:0], ^(lfsr_q & TAPS)});

  assign m_ext = {2'b00, m_q};
  assign t     = {rem_q, shift_q[WIDTH-1]};
  assign t_red = (t >= m_ext) ? (t - m_ext) : t;

  always_comb begin
    state_d = state_q;
    lfsr_d  = lfsr_q;
    shift_d = shift_q;
    byp_d   = byp_q;
    m_d     = m_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    if (bus.seed_load) begin
      lfsr_d  = no_zero(bus.seed);
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req) begin
            lfsr_d  = lfsr_step;
            shift_d = lfsr_step;
            byp_d   = lfsr_step[OUT_W-1:0];
            m_d     = bus.range_max;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = StDiv;
          end else if (FREE_RUN) begin
            lfsr_d = lfsr_step;
          end
        end
        StDiv: begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          rem_d   = (OUT_W+1)'(t_red);
          cnt_d   = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            value_d = (m_q == '0) ? byp_q : OUT_W'(t_red) + OUT_W'(1);
            state_d = StDone;
          end
        end
        StDone: begin
          if (bus.out_ready) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      lfsr_q  <= SEED_INIT;
      shift_q <= '0;
      byp_q   <= '0;
      m_q     <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      shift_q <= shift_d;
      byp_q   <= byp_d;
      m_q     <= m_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.busy      = (state_q == StDiv) || (state_q == StDone);
  assign bus.out_valid = (state_q == StDone);
  assign bus.value     = value_q;
endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng: fixed vectors, hand-built corner sequences and random draws
// against an arithmetic model (LFSR by parity, reduction by plain modulo).
module tb_lfsr_range_rng;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int unsigned ref_state = 1;

  always #5 clk = ~clk;

  lfsr_range_rng_if #(.WIDTH(16), .OUT_W(7)) bus ();

  lfsr_range_rng #(
    .WIDTH(16), .OUT_W(7), .TAPS(16'hB400), .RESET_SEED(16'd1), .FREE_RUN(1'b0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    bit          do_seed;
    logic [15:0] seed;
    logic [6:0]  rm;
    int          exp_value;
  } vec_t;

  function automatic int unsigned ref_step(input int unsigned s);
    int unsigned n;
    n = ((s << 1) & 32'hFFFF) | (int'($countones(s & 32'hB400)) % 2);
    return (n == 0) ? 1 : n;
  endfunction

  function automatic int ref_value(input int unsigned s, input int unsigned rm);
    if (rm == 0) return int'(s % 128);
    return int'(s % rm) + 1;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic load_seed(input logic [15:0] s, input bit with_req);
    @(negedge clk);
    bus.seed_load = 1'b1;
    bus.seed      = s;
    bus.req       = with_req;
    @(negedge clk);
    bus.seed_load = 1'b0;
    bus.req       = 1'b0;
    ref_state     = (s == 0) ? 1 : int'(s);
    if (with_req) begin
      check("seed_req_not_accepted_ready", int'(bus.req_ready), 1);
      check("seed_req_not_accepted_busy", int'(bus.busy), 0);
    end
  endtask

  // One full draw with out_ready high; exp_const < 0 means no fixed expectation.
  task automatic do_draw(input string name, input logic [6:0] rm, input int exp_const);
    int lat;
    int got;
    int exp_model;
    ref_state = ref_step(ref_state);
    exp_model = ref_value(ref_state, rm);
    @(negedge clk);
    bus.req       = 1'b1;
    bus.range_max = rm;
    @(negedge clk);
    bus.req       = 1'b0;
    bus.range_max = 7'(rm + 7'd37);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    got = int'(bus.value);
    check({name, "_latency"}, lat, 16);
    check({name, "_model"}, got, exp_model);
    if (exp_const >= 0) check({name, "_const"}, got, exp_const);
    if (rm != 0) check({name, "_in_range"}, int'(got >= 1 && got <= int'(rm)), 1);
    @(negedge clk);
    check({name, "_ready_back"}, int'(bus.req_ready), 1);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_req_ready"}, int'(bus.req_ready), 1);
    check({name, "_out_valid"}, int'(bus.out_valid), 0);
    check({name, "_busy"}, int'(bus.busy), 0);
    check({name, "_value"}, int'(bus.value), 0);
  endtask

  // Accept a draw and advance to the 5th DIV clock.
  task automatic start_and_wait5(input logic [6:0] rm);
    @(negedge clk);
    bus.req       = 1'b1;
    bus.range_max = rm;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    vec_t vecs[8];
    int   v_hold;
    int   exp_bp;
    int   lat;
    bit   saw_valid;

    vecs[0] = '{do_seed: 1'b0, seed: 16'h0000, rm: 7'd100, exp_value: 3};
    vecs[1] = '{do_seed: 1'b0, seed: 16'h0000, rm: 7'd100, exp_value: 5};
    vecs[2] = '{do_seed: 1'b1, seed: 16'hFFFF, rm: 7'd100, exp_value: 35};
    vecs[3] = '{do_seed: 1'b1, seed: 16'h0000, rm: 7'd100, exp_value: 3};
    vecs[4] = '{do_seed: 1'b0, seed: 16'h0000, rm: 7'd1,   exp_value: 1};
    vecs[5] = '{do_seed: 1'b0, seed: 16'h0000, rm: 7'd0,   exp_value: 8};
    vecs[6] = '{do_seed: 1'b0, seed: 16'h0000, rm: 7'd127, exp_value: 17};
    vecs[7] = '{do_seed: 1'b1, seed: 16'h1234, rm: 7'd10,  exp_value: 2};

    bus.seed_load = 1'b0;
    bus.seed      = '0;
    bus.req       = 1'b0;
    bus.range_max = '0;
    bus.out_ready = 1'b1;

    #2;
    check_reset_vals("reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_seed) load_seed(vecs[i].seed, 1'b0);
      do_draw($sformatf("vec%0d", i), vecs[i].rm, vecs[i].exp_value);
      if (i == 3) check("lockup_lfsr_nonzero", int'(dut.lfsr_q != 16'h0), 1);
    end

    // Seed with a simultaneous req: the req must be dropped.
    load_seed(16'hACE1, 1'b1);
    do_draw("after_seed_req", 7'd50, -1);

    // Backpressure: hold out_ready low for 10 clocks after out_valid, poke req meanwhile.
    bus.out_ready = 1'b0;
    ref_state = ref_step(ref_state);
    exp_bp = ref_value(ref_state, 7'd77);
    @(negedge clk);
    bus.req = 1'b1;
    bus.range_max = 7'd77;
    @(negedge clk);
    bus.req = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", lat, 16);
    check("bp_value", int'(bus.value), exp_bp);
    v_hold = int'(bus.value);
    bus.req = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0 || c == 9) begin
        check($sformatf("bp_hold_valid_%0d", c), int'(bus.out_valid), 1);
        check($sformatf("bp_hold_value_%0d", c), int'(bus.value), v_hold);
        check($sformatf("bp_hold_ready_%0d", c), int'(bus.req_ready), 0);
      end
    end
    bus.req = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", int'(bus.out_valid), 0);
    check("bp_release_ready", int'(bus.req_ready), 1);
    do_draw("after_bp", 7'd99, -1);

    // Abort by seed_load mid-DIV.
    start_and_wait5(7'd60);
    saw_valid = bus.out_valid;
    bus.seed_load = 1'b1;
    bus.seed = 16'h0BAD;
    @(negedge clk);
    bus.seed_load = 1'b0;
    ref_state = 16'h0BAD;
    check("abort_no_valid", int'(saw_valid | bus.out_valid), 0);
    check("abort_idle_ready", int'(bus.req_ready), 1);
    check("abort_idle_busy", int'(bus.busy), 0);
    repeat (20) begin
      @(negedge clk);
      if (bus.out_valid) saw_valid = 1'b1;
    end
    check("abort_valid_stays_low", int'(saw_valid), 0);
    do_draw("abort_next", 7'd100, -1);

    // Abort by reset mid-DIV; the first post-reset bypass draw is 2.
    start_and_wait5(7'd60);
    reset = 1'b1;
    #1;
    check_reset_vals("midreset");
    @(negedge clk);
    reset = 1'b0;
    ref_state = 1;
    do_draw("reset_bypass", 7'd0, 2);

    // Random draws with occasional reseeding and idle gaps.
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 3) == 0) load_seed(16'($urandom), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      do_draw($sformatf("rand%0d", i), 7'($urandom_range(0, 127)), -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
